// File: rtl/lab04_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Pure declarations; no latency or flow control of its own.
package lab04_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} sweep_state_t;

  localparam int SETTLE_CNT_W = 4;

  function automatic int num_vec(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// Loadable down-counter that times the settle interval for each vector.
// Load takes effect next edge; decrement saturates at zero; no backpressure.
module sweep_settle_cnt
  import lab04_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_load,
  input  logic [SETTLE_CNT_W-1:0] i_load_val,
  input  logic                    i_dec,
  output logic                    o_zero
);

  logic [SETTLE_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - SETTLE_CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector onto a combinational function, samples its output and checks it against a latched mask.
// Each vector costs SETTLE+2 cycles, done pulses 2^N_IN*(SETTLE+2)+1 cycles after start; start is ignored while busy.
module truth_table_sweeper
  import lab04_pkg::sweep_state_t, lab04_pkg::num_vec, lab04_pkg::SETTLE_CNT_W;
#(
  parameter  int N_IN   = 4,
  parameter  int SETTLE = 1,
  localparam int NV     = num_vec(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [NV-1:0]   expected,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [NV-1:0]   captured,
  output logic [N_IN-1:0] first_err,
  output logic            err_valid
);

  sweep_state_t    r_state;
  sweep_state_t    w_next;
  logic [N_IN:0]   r_idx;
  logic [NV-1:0]   r_exp_q;
  logic [NV-1:0]   r_captured;
  logic [N_IN-1:0] r_first_err;
  logic            r_err_valid;
  logic            r_pass;
  logic            w_last;
  logic            w_cnt_load;
  logic            w_cnt_dec;
  logic            w_cnt_zero;

  // idx carries one spare bit so the last-vector compare can never wrap to zero
  assign w_last = (r_idx == (N_IN+1)'(NV-1));

  sweep_settle_cnt u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (SETTLE_CNT_W'(SETTLE)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= lab04_pkg::IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      lab04_pkg::IDLE: begin
        if (start) begin
          w_next     = lab04_pkg::SETTLE;
          w_cnt_load = 1'b1;
        end
      end
      lab04_pkg::SETTLE: begin
        if (abort) begin
          w_next = lab04_pkg::IDLE;
        end else if (w_cnt_zero) begin
          w_next = lab04_pkg::SAMPLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      lab04_pkg::SAMPLE: begin
        if (abort) begin
          w_next = lab04_pkg::IDLE;
        end else if (w_last) begin
          w_next = lab04_pkg::FINISH;
        end else begin
          w_next     = lab04_pkg::SETTLE;
          w_cnt_load = 1'b1;
        end
      end
      lab04_pkg::FINISH: w_next = lab04_pkg::IDLE;
      default:           w_next = lab04_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_exp_q     <= '0;
      r_captured  <= '0;
      r_first_err <= '0;
      r_err_valid <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        lab04_pkg::IDLE: begin
          if (start) begin
            r_idx       <= '0;
            r_exp_q     <= expected;
            r_captured  <= '0;
            r_first_err <= '0;
            r_err_valid <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        lab04_pkg::SETTLE: begin
          if (abort) begin
            r_idx  <= '0;
            r_pass <= 1'b0;
          end
        end
        lab04_pkg::SAMPLE: begin
          if (abort) begin
            r_idx  <= '0;
            r_pass <= 1'b0;
          end else begin
            r_captured[r_idx[N_IN-1:0]] <= dut_y;
            if ((dut_y != r_exp_q[r_idx[N_IN-1:0]]) && !r_err_valid) begin
              r_first_err <= r_idx[N_IN-1:0];
              r_err_valid <= 1'b1;
            end
            if (!w_last) begin
              r_idx <= r_idx + (N_IN+1)'(1);
            end
          end
        end
        lab04_pkg::FINISH: r_pass <= !r_err_valid;
        default: ;
      endcase
    end
  end

  assign dut_in    = r_idx[N_IN-1:0];
  assign busy      = (r_state != lab04_pkg::IDLE);
  assign done      = (r_state == lab04_pkg::FINISH);
  assign pass      = r_pass;
  assign captured  = r_captured;
  assign first_err = r_first_err;
  assign err_valid = r_err_valid;

endmodule
